// File: rtl/vec_mem_pkg.sv
// Shared types, default sizes and the lane-address helper for the vector memory controller.
package vec_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int DEF_LANES  = 16;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_DEPTH  = 512;

  // Word address of one lane before truncation; callers cut it to their address width,
  // which gives the natural mod-DEPTH wrap.
  function automatic logic [31:0] lane_addr(input logic [31:0] base,
                                            input logic [31:0] stride,
                                            input logic [31:0] lane);
    return base + lane * stride;
  endfunction

endpackage

// File: rtl/vec_mem_if.sv
// Request/response bus between a vector client (master) and vec_mem_ctrl (slave).
interface vec_mem_if
  import vec_mem_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int WORD_W = DEF_WORD_W,
  parameter int ADDR_W = $clog2(DEF_DEPTH)
);

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [ADDR_W-1:0]         req_addr;
  logic [ADDR_W-1:0]         req_stride;
  logic [LANES-1:0]          req_mask;
  logic [LANES*WORD_W-1:0]   req_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [LANES*WORD_W-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_stride, req_mask, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_stride, req_mask, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/vec_mem_lane_addr.sv
// Per-lane word addresses from base and stride.
// Strided addressing is built only when VEC_MEM_STRIDE_EN is defined; otherwise lanes are
// contiguous (stride 1) and the stride input is ignored.
module vec_mem_lane_addr
  import vec_mem_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int ADDR_W = $clog2(DEF_DEPTH)
) (
  input  logic [ADDR_W-1:0]       base,
  input  logic [ADDR_W-1:0]       stride,
  output logic [LANES*ADDR_W-1:0] addrs
);

`ifdef VEC_MEM_STRIDE_EN
  // Lane i sits at base + i*stride, wrapped by truncation.
  always_comb begin
    addrs = '0;
    for (int i = 0; i < LANES; i++) begin
      addrs[i*ADDR_W +: ADDR_W] = ADDR_W'(lane_addr(32'(base), 32'(stride), 32'(i)));
    end
  end
`else
  logic unused_stride;
  assign unused_stride = ^stride;

  // Lane i sits at base + i, wrapped by truncation.
  always_comb begin
    addrs = '0;
    for (int i = 0; i < LANES; i++) begin
      addrs[i*ADDR_W +: ADDR_W] = ADDR_W'(lane_addr(32'(base), 32'd1, 32'(i)));
    end
  end
`endif

endmodule

// File: rtl/vec_mem_ctrl.sv
// Vector memory controller: masked gather/scatter over a single word array, cleared after reset.
// Optional build macro: VEC_MEM_STRIDE_EN (honour req_stride; default is unit stride).
//
// state | meaning
// CLEAR | zeroing LANES words per cycle from word 0; no requests accepted
// IDLE  | serving vector reads/writes; init_done high
module vec_mem_ctrl
  import vec_mem_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int WORD_W = DEF_WORD_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  vec_mem_if.slave   bus,
  output logic       init_done
);

  localparam int ADDR_W     = $clog2(DEPTH);
  localparam int CLR_CYCLES = DEPTH / LANES;
  localparam int CNT_W      = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLR_CYCLES - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         clr_cnt;
  logic signed [WORD_W-1:0] mem [DEPTH];
  logic [LANES*ADDR_W-1:0]  lane_addrs;
  logic [LANES*WORD_W-1:0]  rd_gather;
  logic                     wr_acc;
  logic                     rd_acc;

  vec_mem_lane_addr #(
    .LANES  (LANES),
    .ADDR_W (ADDR_W)
  ) u_lane_addr (
    .base   (bus.req_addr),
    .stride (bus.req_stride),
    .addrs  (lane_addrs)
  );

  assign wr_acc = bus.req_valid && bus.req_ready &&  bus.req_we;
  assign rd_acc = bus.req_valid && bus.req_ready && !bus.req_we;

  // State register and clear-sweep counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        clr_cnt <= (clr_cnt == CNT_LAST) ? '0 : clr_cnt + 1'b1;
      end
    end
  end

  // Next state: leave CLEAR once the last block of words has been zeroed.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_cnt == CNT_LAST) state_nxt = IDLE;
      IDLE:    state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // Handshake outputs: reads stall only while an unconsumed response is held.
  always_comb begin
    bus.req_ready = 1'b0;
    init_done     = 1'b0;
    if (state == IDLE) begin
      init_done     = 1'b1;
      bus.req_ready = bus.req_we || !bus.rsp_valid || bus.rsp_ready;
    end
  end

  // Read gather: enabled lanes fetch their word, disabled lanes read as zero.
  always_comb begin
    rd_gather = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.req_mask[i]) begin
        rd_gather[i*WORD_W +: WORD_W] = mem[lane_addrs[i*ADDR_W +: ADDR_W]];
      end
    end
  end

  // Storage: clear sweep, or masked scatter where the later (higher) lane wins on aliasing.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      for (int j = 0; j < LANES; j++) begin
        mem[ADDR_W'(32'(clr_cnt) * LANES + j)] <= '0;
      end
    end else if (wr_acc) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.req_mask[i]) begin
          mem[lane_addrs[i*ADDR_W +: ADDR_W]] <= bus.req_wdata[i*WORD_W +: WORD_W];
        end
      end
    end
  end

  // Response register: load on an accepted read, hold while stalled, drop once consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else if (rd_acc) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_rdata <= rd_gather;
    end else if (bus.rsp_valid && bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vec_mem_ctrl.sv
// Self-checking bench for vec_mem_ctrl: directed vector table, handshake sequences,
// randomized traffic against a word-array reference model, and reset behaviour.
module tb_vec_mem_ctrl;
  import vec_mem_pkg::*;

  localparam int LANES  = 16;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
  localparam int DW     = LANES * WORD_W;

  logic clk = 1'b0;
  logic reset;
  logic init_done;

  always #5 clk = ~clk;

  vec_mem_if #(.LANES(LANES), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  vec_mem_ctrl #(.LANES(LANES), .WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .init_done (init_done)
  );

  int tests = 0;
  int fails = 0;

  logic [WORD_W-1:0] model_mem [DEPTH];
  bit                m_valid;
  logic [DW-1:0]     m_rdata;

  typedef struct {
    string          name;
    bit             we;
    int             addr;
    int             stride;
    logic [LANES-1:0] mask;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic int eff_stride(input int s);
`ifdef VEC_MEM_STRIDE_EN
    return s;
`else
    return 1;
`endif
  endfunction

  function automatic int word_of(input int addr, input int stride, input int lane);
    return (addr + lane * eff_stride(stride)) % DEPTH;
  endfunction

  function automatic logic [DW-1:0] model_read(input int addr, input int stride,
                                               input logic [LANES-1:0] mask);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      if (mask[i]) r[i*WORD_W +: WORD_W] = model_mem[word_of(addr, stride, i)];
    return r;
  endfunction

  task automatic model_write(input int addr, input int stride, input logic [LANES-1:0] mask,
                             input logic [DW-1:0] wdata);
    for (int i = 0; i < LANES; i++)
      if (mask[i]) model_mem[word_of(addr, stride, i)] = wdata[i*WORD_W +: WORD_W];
  endtask

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
  endtask

  function automatic logic [DW-1:0] lanes_const(input logic [WORD_W-1:0] v,
                                                input logic [LANES-1:0] m);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) if (m[i]) r[i*WORD_W +: WORD_W] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] lanes_seq(input int start);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*WORD_W +: WORD_W] = WORD_W'(start + i);
    return r;
  endfunction

  task automatic drive(input bit we, input int addr, input int stride,
                       input logic [LANES-1:0] mask, input logic [DW-1:0] wdata);
    bus.req_we     = we;
    bus.req_addr   = ADDR_W'(addr);
    bus.req_stride = ADDR_W'(stride);
    bus.req_mask   = mask;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
  endtask

  // Issue one request, wait (bounded) for acceptance, update the model; called at posedge+1.
  task automatic do_req(input string name, input bit we, input int addr, input int stride,
                        input logic [LANES-1:0] mask, input logic [DW-1:0] wdata);
    int k;
    drive(we, addr, stride, mask, wdata);
    #1;
    k = 0;
    while (!bus.req_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 50) begin
      tests++;
      fails++;
      $display("FAIL %s_accept: got no req_ready expected acceptance within 50 cycles", name);
    end
    @(posedge clk);
    if (we) model_write(addr, stride, mask, wdata);
    else begin
      m_rdata = model_read(addr, stride, mask);
      m_valid = 1'b1;
    end
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic count_clear(input string name);
    int n;
    n = 0;
    while (!init_done && n < 40) begin
      chk_bit({name, "_ready_low"}, bus.req_ready, 1'b0);
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_clear_cycles"}, DW'(n), DW'(32));
  endtask

  initial begin
    bit               we, acc, exp_ready;
    int               addr, stride;
    logic [LANES-1:0] mask;
    logic [DW-1:0]    wdata;

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_stride = '0;
    bus.req_mask   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    m_valid        = 1'b0;
    m_rdata        = '0;
    model_clear();

    vecs[0] = '{"w_stride4", 1'b1, 0, 4, 16'h00FF, lanes_const(32'hA5, 16'hFFFF), '0};
    vecs[1] = '{"r_stride4", 1'b0, 0, 4, 16'hFFFF, '0, lanes_const(32'hA5, 16'h00FF)};
`ifdef VEC_MEM_STRIDE_EN
    vecs[2] = '{"r_word1", 1'b0, 1, 1, 16'h0001, '0, '0};
`else
    vecs[2] = '{"r_word1", 1'b0, 1, 1, 16'h0001, '0, lanes_const(32'hA5, 16'h0001)};
`endif
    vecs[3] = '{"w_alias", 1'b1, 100, 0, 16'h0005,
                {lanes_const(32'd0, 16'h0000)} | DW'(32'd11) | (DW'(32'd22) << (2*WORD_W)), '0};
`ifdef VEC_MEM_STRIDE_EN
    vecs[4] = '{"r_alias", 1'b0, 100, 0, 16'h0001, '0, DW'(32'd22)};
`else
    vecs[4] = '{"r_alias", 1'b0, 100, 0, 16'h0001, '0, DW'(32'd11)};
`endif
    vecs[5] = '{"w_wrap", 1'b1, 510, 1, 16'hFFFF, lanes_seq(1), '0};
    vecs[6] = '{"r_wrap", 1'b0, 510, 1, 16'hFFFF, '0, lanes_seq(1)};
    vecs[7] = '{"r_lane2", 1'b0, 0, 1, 16'h0004, '0, DW'(32'd5) << (2*WORD_W)};

    // Reset state, then the CLEAR window with a read held pending.
    #1;
    chk_bit("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, '0);
    chk_bit("rst_init_done", init_done, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 0, 1, 16'hFFFF, '0);
    #1;
    for (int c = 1; c <= 32; c++) begin
      chk_bit($sformatf("clr_ready_c%0d", c), bus.req_ready, 1'b0);
      chk_bit($sformatf("clr_init_c%0d", c), init_done, 1'b0);
      @(posedge clk); #1;
    end
    chk_bit("init_done_c33", init_done, 1'b1);
    chk_bit("ready_c33", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk_bit("first_read_valid", bus.rsp_valid, 1'b1);
    chk("first_read_data", bus.rsp_rdata, '0);
    @(posedge clk); #1;

    // Directed vector table.
    for (int v = 0; v < 8; v++) begin
      do_req(vecs[v].name, vecs[v].we, vecs[v].addr, vecs[v].stride, vecs[v].mask,
             vecs[v].wdata);
      if (!vecs[v].we) begin
        chk_bit({vecs[v].name, "_valid"}, bus.rsp_valid, 1'b1);
        chk(vecs[v].name, bus.rsp_rdata, vecs[v].exp);
      end else begin
        chk_bit({vecs[v].name, "_no_rsp"}, bus.rsp_valid, 1'b0);
      end
      @(posedge clk); #1;
      m_valid = 1'b0;
    end

    // Back-to-back reads under response backpressure.
    bus.rsp_ready = 1'b0;
    drive(1'b0, 510, 1, 16'h0001, '0);
    #1;
    chk_bit("b2b_c1_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    chk_bit("b2b_c1_valid", bus.rsp_valid, 1'b1);
    chk("b2b_c1_data", bus.rsp_rdata, DW'(32'd1));
    drive(1'b0, 0, 1, 16'h0001, '0);
    #1;
    chk_bit("b2b_c2_ready", bus.req_ready, 1'b0);
    @(posedge clk); #1;
    chk_bit("b2b_c2_valid", bus.rsp_valid, 1'b1);
    chk("b2b_c2_hold", bus.rsp_rdata, DW'(32'd1));
    bus.rsp_ready = 1'b1;
    #1;
    chk_bit("b2b_c3_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    chk_bit("b2b_c3_valid", bus.rsp_valid, 1'b1);
    chk("b2b_c3_data", bus.rsp_rdata, DW'(32'd3));
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk_bit("b2b_drain", bus.rsp_valid, 1'b0);
    m_valid = 1'b0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      we     = ($urandom_range(0, 2) == 0);
      addr   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 31) : $urandom_range(480, 511);
      stride = $urandom_range(0, 3);
      mask   = LANES'($urandom);
      for (int i = 0; i < LANES; i++) wdata[i*WORD_W +: WORD_W] = $urandom;
      drive(we, addr, stride, mask, wdata);
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_ready = we || !m_valid || bus.rsp_ready;
      chk_bit("rnd_ready", bus.req_ready, exp_ready);
      acc = bus.req_valid && exp_ready;
      @(posedge clk);
      if (acc && !we) begin
        m_rdata = model_read(addr, stride, mask);
        m_valid = 1'b1;
      end else if (m_valid && bus.rsp_ready) begin
        m_valid = 1'b0;
      end
      if (acc && we) model_write(addr, stride, mask, wdata);
      #1;
      chk_bit("rnd_rsp_valid", bus.rsp_valid, m_valid);
      if (m_valid) chk("rnd_rsp_data", bus.rsp_rdata, m_rdata);
    end

    // Reset with a pending response, then reset again mid-CLEAR.
    bus.rsp_ready = 1'b0;
    drive(1'b0, 510, 1, 16'hFFFF, '0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk_bit("pre_reset_pending", bus.rsp_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_bit("async_rst_valid", bus.rsp_valid, 1'b0);
    chk("async_rst_rdata", bus.rsp_rdata, '0);
    chk_bit("async_rst_ready", bus.req_ready, 1'b0);
    chk_bit("async_rst_init", init_done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    drive(1'b0, 0, 1, 16'hFFFF, '0);
    repeat (10) @(posedge clk);
    #1;
    chk_bit("mid_clear_init", init_done, 1'b0);
    reset = 1'b1;
    #1;
    chk_bit("mid_clear_rst_valid", bus.rsp_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    count_clear("restart");
    bus.req_valid = 1'b0;
    model_clear();
    m_valid = 1'b0;
    do_req("post_clear_read", 1'b0, 510, 1, 16'hFFFF, '0);
    chk_bit("post_clear_valid", bus.rsp_valid, 1'b1);
    chk("post_clear_data", bus.rsp_rdata, model_read(510, 1, 16'hFFFF));
    chk("post_clear_zero", bus.rsp_rdata, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always reaches its summary.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000 time units");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
